rr_stream_mux: RTL



---
 rtl/rr_stream_mux.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rr_stream_mux.sv
// Purpose : N-channel round-robin stream mux with optional packet-hold grant, registered output tagged by source channel.
// Latency : one cycle from input accept to out_* (out_* driven straight from flops).
// Backpr. : in_ready is granted only when the output register has space (!out_valid || out_ready); a stall freezes out_*.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_last       per-channel valid and end-of-packet flags (N_CH bits)
//   in_data                channel i at [i*WIDTH +: WIDTH]
//   in_ready               per-channel ready, one-hot or zero
//   out_valid/out_data/out_last/out_ch   registered output beat and its source channel
//   out_ready              consumer accepts the output beat
module rr_stream_mux #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int PKT_MODE = 1,
  localparam int CW      = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [CW-1:0]         out_ch,
  input  logic                  out_ready
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_ptr;
  logic [CW-1:0]    r_lck;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [CW-1:0]    r_out_ch;

  logic [CW-1:0]    w_arb_ch;
  logic             w_arb_hit;
  logic [CW-1:0]    w_gnt_ch;
  logic             w_gnt_en;
  logic             w_space;
  logic             w_accept;
  logic             w_gnt_last;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_hold;
  logic [CW-1:0]    w_ptr_nxt;

  // Round-robin search starting at r_ptr; the modulo keeps non-power-of-two
  // channel counts from indexing a channel that does not exist.
  always_comb begin
    int idx;
    idx       = 0;
    w_arb_ch  = '0;
    w_arb_hit = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(r_ptr) + k) % N_CH;
      if (!w_arb_hit && in_valid[idx]) begin
        w_arb_hit = 1'b1;
        w_arb_ch  = CW'(idx);
      end
    end
  end

  // While locked the grant stays on r_lck even if that channel is stalled,
  // so a packet is never interleaved with another channel's beats.
  assign w_gnt_ch   = (r_state == S_LOCKED) ? r_lck : w_arb_ch;
  assign w_gnt_en   = (r_state == S_LOCKED) ? 1'b1  : w_arb_hit;
  // Ready is suppressed while reset is asserted so nothing is offered then.
  assign w_space    = (!r_out_valid || out_ready) && rst_n;
  assign w_accept   = w_gnt_en && w_space && in_valid[w_gnt_ch];
  assign w_gnt_last = in_last[w_gnt_ch];
  assign w_gnt_data = in_data[int'(w_gnt_ch)*WIDTH +: WIDTH];
  assign w_hold     = (PKT_MODE != 0) && !w_gnt_last;
  assign w_ptr_nxt  = (w_gnt_ch == CW'(N_CH-1)) ? '0 : w_gnt_ch + CW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && w_hold)  w_state_nxt = S_LOCKED;
      S_LOCKED: if (w_accept && !w_hold) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: single ready bit toward the granted channel
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = w_gnt_en && w_space && (w_gnt_ch == CW'(i));
    end
  end

  // Pointer, lock and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_lck       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_last  <= w_gnt_last;
      r_out_ch    <= w_gnt_ch;
      // Mid-packet beats keep the pointer so priority advances per packet.
      if (w_hold) begin
        r_lck <= w_gnt_ch;
      end else begin
        r_ptr <= w_ptr_nxt;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule
